dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Load/store sequencer between the pipeline's memory stage and the word-only data memory (`DataMem`). It accepts one byte, halfword or word request at a time over a valid/ready handshake and performs the required word-aligned read, write or read-modify-write. Sub-word stores are built from a read followed by a write, because the data memory supports whole-word writes only and cannot read and write in the same cycle. Load data is returned lane-extracted and sign- or zero-extended, and misaligned accesses are rejected without touching memory.

## Interface
Parameters:
- `WordSize`, 32: data and address width.

Ports:
- `CLK` in 1: the single clock. `DataMem` commits writes on its falling edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; the request is accepted on the rising edge where `req_valid` and `req_ready` are both 1.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in WordSize: byte address.
- `req_wdata` in WordSize: store data, right-justified (byte in [7:0], halfword in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out WordSize: load result; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; set for a misaligned address or illegal size.
- `Mem_Addr` out WordSize: word-aligned address to `DataMem`.
- `Mem_rd` out 1: read enable to `DataMem`.
- `Mem_wr` out 1: write enable to `DataMem`.
- `Mem_DIN` out WordSize: write data to `DataMem`.
- `Mem_DOUT` in WordSize: read data from `DataMem`.

## Operation
- States: IDLE, READ, RMW_READ, RMW_WRITE, WRITE, DONE.
- IDLE:
  - `req_ready`=1 and all memory strobes are 0.
  - On accept, latch addr, size, signed, wr and wdata.
  - `Mem_Addr` = {addr[31:2], 2'b00}, held constant until DONE.
- Decode at accept:
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]≠0) or size 11: go to DONE with `resp_err`=1. No memory strobe is ever asserted.
  - Load: go to READ.
  - Word store: go to WRITE.
  - Byte/halfword store: go to RMW_READ.
- READ / RMW_READ:
  - `Mem_rd`=1 for exactly one cycle.
  - `Mem_DOUT` is captured into an internal word register at the closing rising edge.
- Lane order is little-endian:
  - Byte lane = addr[1:0]; byte 0 is bits [7:0].
  - Halfword lane = addr[1]; lane 0 is bits [15:0].
- Load result: the extracted lane, extended to WordSize according to `req_signed`. A word load returns the full word.
- RMW_WRITE:
  - `Mem_wr`=1.
  - `Mem_DIN` = captured word with the selected lane replaced by wdata[7:0] or wdata[15:0]; all other bytes unchanged.
- WRITE: `Mem_wr`=1, `Mem_DIN`=wdata.
- DONE: `resp_valid`=1 for one cycle, then return to IDLE. There is no back-pressure on responses.
- Invariants:
  - `Mem_rd` and `Mem_wr` are never 1 in the same cycle.
  - `Mem_rd` is 0 in IDLE and DONE, so every read produces a fresh `Mem_rd` rising transition. `DataMem` re-evaluates only on a change of address or `Mem_rd`.
  - All outputs are registered; none is combinational from `req_*`.

## Timing
- Reset (`RST_N`=0, takes effect immediately):
  - State = IDLE, `req_ready`=1.
  - `resp_valid`, `resp_err`, `resp_rdata`, `Mem_Addr`, `Mem_rd`, `Mem_wr`, `Mem_DIN` all = 0.
- Latency, counted as the cycle in which `resp_valid`=1, relative to the accepting edge E0:
  - Load: cycle 2 (READ, then DONE).
  - Word store: cycle 2.
  - Sub-word store: cycle 3.
  - Error: cycle 1.
- Next accept is possible at the edge after DONE. Throughput is one request per 3 cycles for a load or word store.
- Clock period must be at least 2×`T_rd` of `DataMem`, so that `Mem_DOUT` settles before the rising edge that closes READ.
- Store commit: the memory word updates at the falling edge inside WRITE or RMW_WRITE. A load issued right after a store to the same word sees the new value.
- Reset during any state:
  - Strobes drop immediately and no response is produced.
  - If reset arrives before the falling edge of a write cycle, the target word is not guaranteed updated; otherwise it is.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Preload word 0x10 = 0x8899AABB.
  - Load byte, signed, addr 0x11: `resp_rdata`=0xFFFFFFAA at cycle 2.
  - Same load unsigned: 0x000000AA.
- Load halfword, signed, addr 0x12 (word 0x10 = 0x8899AABB): 0xFFFF8899.
- Store halfword, wdata 0x00001234, addr 0x12:
  - `Mem_rd` for one cycle, then `Mem_wr` with `Mem_DIN`=0x1234AABB; `resp_valid` at cycle 3.
  - A following load word at 0x10 returns 0x1234AABB.
- Store word to 0x13, and a request with size 11:
  - `resp_err`=1 at cycle 1, `resp_rdata`=0.
  - `Mem_rd`/`Mem_wr` never asserted; memory unchanged.
- Hold `req_valid`=1 for 4 back-to-back loads: each is accepted only when `req_ready`=1, each gets exactly one `resp_valid` pulse, and `Mem_rd`/`Mem_wr` never overlap.
- Assert `RST_N`=0 during RMW_READ:
  - All outputs are 0 and `req_ready`=1 immediately.
  - No `resp_valid` and no memory write occur.
  - A new request after release completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the memory stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module dmem_access_ctrl #(
  parameter int WordSize = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [WordSize-1:0] req_addr,
  input  logic [WordSize-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WordSize-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WordSize-1:0] Mem_Addr,
  output logic                Mem_rd,
  output logic                Mem_wr,
  output logic [WordSize-1:0] Mem_DIN,
  input  logic [WordSize-1:0] Mem_DOUT,
  output logic [2:0]          dbg_state
);

  // Handshake: a request is taken on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single unthrottled pulse.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    RMW_READ  = 3'd2,
    RMW_WRITE = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        signed_q;
  logic [15:0] wdata_q;

  logic                accept;
  logic                bad_req;
  logic [4:0]          lane_shift;
  logic [WordSize-1:0] lane_word;
  logic [WordSize-1:0] load_data;
  logic [WordSize-1:0] lane_mask;
  logic [WordSize-1:0] merged;

  logic                req_ready_d, resp_valid_d, resp_err_d, mem_rd_d, mem_wr_d;
  logic [WordSize-1:0] resp_rdata_d, mem_addr_d, mem_din_d;

  assign accept  = req_valid && req_ready;
  assign bad_req = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign dbg_state = state;

  // Lane handling works on the raw memory word so the result is ready at the closing edge of the read.
  assign lane_shift = {lane_q, 3'b000};
  assign lane_word  = Mem_DOUT >> lane_shift;

  always_comb begin
    load_data = Mem_DOUT;
    case (size_q)
      2'b00:   load_data = {{(WordSize-8){signed_q & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_data = {{(WordSize-16){signed_q & lane_word[15]}}, lane_word[15:0]};
      default: load_data = Mem_DOUT;
    endcase
  end

  assign lane_mask = ((size_q == 2'b00) ? WordSize'(8'hFF) : WordSize'(16'hFFFF)) << lane_shift;
  assign merged    = (Mem_DOUT & ~lane_mask) | ((WordSize'(wdata_q) << lane_shift) & lane_mask);

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      Mem_Addr   <= '0;
      Mem_rd     <= 1'b0;
      Mem_wr     <= 1'b0;
      Mem_DIN    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        size_q   <= req_size;
        lane_q   <= req_addr[1:0];
        signed_q <= req_signed;
        wdata_q  <= req_wdata[15:0];
      end
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      Mem_Addr   <= mem_addr_d;
      Mem_rd     <= mem_rd_d;
      Mem_wr     <= mem_wr_d;
      Mem_DIN    <= mem_din_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_req)                 state_nxt = DONE;
          else if (!req_wr)            state_nxt = READ;
          else if (req_size == 2'b10)  state_nxt = WRITE;
          else                         state_nxt = RMW_READ;
        end
      end
      READ:      state_nxt = DONE;
      RMW_READ:  state_nxt = RMW_WRITE;
      RMW_WRITE: state_nxt = DONE;
      WRITE:     state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    req_ready_d  = (state_nxt == IDLE);
    resp_valid_d = (state_nxt == DONE);
    resp_err_d   = (state == IDLE) && (state_nxt == DONE);
    mem_rd_d     = (state_nxt == READ) || (state_nxt == RMW_READ);
    mem_wr_d     = (state_nxt == WRITE) || (state_nxt == RMW_WRITE);
    resp_rdata_d = (state == READ) ? load_data : '0;
    mem_addr_d   = accept ? {req_addr[WordSize-1:2], 2'b00} : Mem_Addr;
    mem_din_d    = Mem_DIN;
    if (accept && state_nxt == WRITE) mem_din_d = req_wdata;
    else if (state == RMW_READ)       mem_din_d = merged;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small word memory that writes on the falling edge.
module tb_dmem_access_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Mem_Addr;
  logic        Mem_rd;
  logic        Mem_wr;
  logic [31:0] Mem_DIN;
  logic [31:0] Mem_DOUT;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic        mem_init = 1'b0;
  int          rd_total = 0;
  int          wr_total = 0;
  int          resp_total = 0;
  int          overlap = 0;
  logic [31:0] last_din = '0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;

  dmem_access_ctrl #(.WordSize(32)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .Mem_Addr   (Mem_Addr),
    .Mem_rd     (Mem_rd),
    .Mem_wr     (Mem_wr),
    .Mem_DIN    (Mem_DIN),
    .Mem_DOUT   (Mem_DOUT),
    .dbg_state  (dbg_state)
  );

  // Clock and memory model
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign Mem_DOUT = Mem_rd ? mem[Mem_Addr[5:2]] : 32'hDEADBEEF;

  always @(negedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h01010101 * i;
      mem[4] = 32'h8899AABB;
      mem_init = 1'b1;
    end
    if (Mem_rd) begin
      rd_total++;
      last_rd_addr = Mem_Addr;
    end
    if (Mem_wr) begin
      wr_total++;
      last_din = Mem_DIN;
      last_wr_addr = Mem_Addr;
      mem[Mem_Addr[5:2]] = Mem_DIN;
    end
    if (Mem_rd && Mem_wr) overlap++;
    if (resp_valid) resp_total++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: issue one request from IDLE and check latency, response and strobes.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_rd,
                        input int exp_wr, input logic [31:0] exp_din);
    int lat;
    int c;
    int rd0;
    int wr0;
    logic [31:0] rdata;
    logic err;
    lat = 0;
    rdata = '0;
    err = 1'b0;
    rd0 = rd_total;
    wr0 = wr_total;
    check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_wr = wr;
    req_size = size;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    c = 1;
    while (lat == 0 && c <= 8) begin
      if (resp_valid) begin
        lat = c;
        rdata = resp_rdata;
        err = resp_err;
      end else begin
        @(posedge CLK);
        #1;
        c++;
      end
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_err"}, 32'(err), 32'(exp_err));
    check_val({tag, "_rdata"}, rdata, exp_rdata);
    @(posedge CLK);
    #1;
    check_val({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check_val({tag, "_rd_cnt"}, 32'(rd_total - rd0), 32'(exp_rd));
    check_val({tag, "_wr_cnt"}, 32'(wr_total - wr0), 32'(exp_wr));
    if (exp_rd != 0) check_val({tag, "_rd_addr"}, last_rd_addr, {addr[31:2], 2'b00});
    if (exp_wr != 0) begin
      check_val({tag, "_wr_addr"}, last_wr_addr, {addr[31:2], 2'b00});
      check_val({tag, "_din"}, last_din, exp_din);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_val({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_val({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check_val({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check_val({tag, "_mem_addr"}, Mem_Addr, 32'd0);
    check_val({tag, "_mem_rd"}, 32'(Mem_rd), 32'd0);
    check_val({tag, "_mem_wr"}, 32'(Mem_wr), 32'd0);
    check_val({tag, "_mem_din"}, Mem_DIN, 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  int accepts;
  int resps;
  int cyc;
  int acc_cyc [4];
  int rd_start;
  int wr_start;
  int resp_start;
  logic r_seen;
  logic v_seen;

  initial begin
    RST_N = 1'b0;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Loads from word 0x10 = 0x8899AABB
    do_req("lb_s_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 1'b0, 32'hFFFFFFAA, 1, 0, 32'h0);
    do_req("lb_u_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1'b0, 32'h000000AA, 1, 0, 32'h0);
    do_req("lh_s_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8899, 1, 0, 32'h0);
    do_req("lh_u_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0000AABB, 1, 0, 32'h0);
    do_req("lb_s_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF88, 1, 0, 32'h0);
    do_req("lb_s_10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFFFBB, 1, 0, 32'h0);
    do_req("lh_s_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFAABB, 1, 0, 32'h0);

    // Sub-word stores as read-modify-write
    do_req("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 3, 1'b0, 32'h0, 1, 1, 32'h1234AABB);
    check_val("sh_12_mem", mem[4], 32'h1234AABB);
    do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h1234AABB, 1, 0, 32'h0);
    do_req("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFCD, 3, 1'b0, 32'h0, 1, 1, 32'h1234CDBB);
    check_val("sb_11_mem", mem[4], 32'h1234CDBB);

    // Word store and read back
    do_req("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 2, 1'b0, 32'h0, 0, 1, 32'hCAFEF00D);
    check_val("sw_20_mem", mem[8], 32'hCAFEF00D);
    do_req("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'hCAFEF00D, 1, 0, 32'h0);

    // Rejected requests never strobe memory
    do_req("err_sw_13", 1'b1, 2'b10, 1'b0, 32'h13, 32'h55555555, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    do_req("err_size3", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    do_req("err_lh_11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    do_req("err_sh_13", 1'b1, 2'b01, 1'b0, 32'h13, 32'h7777, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    check_val("err_mem", mem[4], 32'h1234CDBB);

    // Back-to-back loads with req_valid held high
    accepts = 0;
    resps = 0;
    cyc = 0;
    rd_start = rd_total;
    req_wr = 1'b0;
    req_size = 2'b10;
    req_signed = 1'b0;
    req_addr = 32'h20;
    req_valid = 1'b1;
    while ((accepts < 4 || resps < 4) && cyc < 40) begin
      r_seen = req_ready;
      v_seen = req_valid;
      @(posedge CLK);
      #1;
      cyc++;
      if (r_seen && v_seen) begin
        acc_cyc[accepts] = cyc;
        accepts++;
        if (accepts == 4) req_valid = 1'b0;
      end
      if (resp_valid) begin
        resps++;
        check_val("b2b_rdata", resp_rdata, 32'hCAFEF00D);
      end
    end
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    check_val("b2b_accepts", 32'(accepts), 32'd4);
    check_val("b2b_resps", 32'(resps), 32'd4);
    for (int k = 1; k < 4; k++) check_val("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
    check_val("b2b_rd_cnt", 32'(rd_total - rd_start), 32'd4);
    check_val("overlap", 32'(overlap), 32'd0);

    // Reset in the middle of a read-modify-write
    wr_start = wr_total;
    resp_start = resp_total;
    req_wr = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h10;
    req_wdata = 32'h00000055;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check_val("rst_mid_state", 32'(dbg_state), 32'd2);
    check_val("rst_mid_rd", 32'(Mem_rd), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_val("rst_mid_wr_cnt", 32'(wr_total - wr_start), 32'd0);
    check_val("rst_mid_resp_cnt", 32'(resp_total - resp_start), 32'd0);
    check_val("rst_mid_mem", mem[4], 32'h1234CDBB);
    do_req("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h1234CDBB, 1, 0, 32'h0);
    do_req("post_rst_sb", 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000EE, 3, 1'b0, 32'h0, 1, 1, 32'hEE34CDBB);
    check_val("post_rst_mem", mem[4], 32'hEE34CDBB);
    check_val("overlap_final", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
